// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit (shift-add / restoring).
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            c_CW   = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q, r_neg_r;
    logic [XLEN-1:0] r_hi, r_lo, r_opd, r_result;

    // Operand decode at accept time
    logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;
    logic            w_div0, w_ovf, w_special;

    assign w_is_div = funct3[2];
    assign w_a_sgn  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign w_b_sgn  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg  = w_a_sgn & a[XLEN-1];
    assign w_b_neg  = w_b_sgn & b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

    assign w_div0    = w_is_div && (b == '0);
    assign w_ovf     = w_is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (funct3[1] ? a : '1)
                                  : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration: {r_hi,r_lo} is the product shifter or remainder/quotient pair
    logic [XLEN-1:0] w_addend, w_diff, w_hi_nxt, w_lo_nxt;
    logic [XLEN:0]   w_sum, w_shift;
    logic            w_ge;

    assign w_addend = r_lo[0] ? r_opd : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_shift  = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opd});
    assign w_diff   = w_shift[XLEN-1:0] - r_opd;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op[2]) begin
            w_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Sign restoration applied on the final iteration's values
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
    assign w_rem_s  = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
    assign w_final  = r_op[2] ? (r_op[1] ? w_rem_s : w_quo_s)
                              : ((r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                      : w_prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_DONE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= funct3;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_cnt   <= '0;
                    r_hi    <= '0;
                    r_opd   <= w_is_div ? w_b_mag : w_a_mag;
                    r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                    if (w_special) r_result <= w_special_res;
                end
                S_CALC: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      uy = longint'({32'b0, y});
        int          xi = x;
        int          yi = y;
        logic [63:0] p;
        case (f3)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * uy; return p[63:32]; end
            3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return xi / yi;
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return xi % yi;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        if (f3[2] && y == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op; skip_neg lets the caller drive start on the current negedge
    task automatic do_op(input bit skip_neg, input logic [2:0] f3, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
        int          k;
        logic [31:0] e;
        e = model(f3, x, y);
        if (!skip_neg) @(negedge clk);
        funct3 = f3; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
        k = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, latency(f3, x, y));
        chk({tag, "_res"}, result, e);
        last_exp = e;
        @(negedge clk);
        chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        int          k;
        logic        seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", {29'b0, busy, done, 1'b0}, 32'd0);
        chk("reset_res", result, 32'd0);
        rst = 1'b0;

        do_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, "mul");
        do_op(0, 3'b001, 32'd7, 32'hFFFF_FFFD, "mulh");
        do_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        do_op(0, 3'b010, 32'hFFFF_FFFF, 32'd2, "mulhsu");
        do_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, "div");
        do_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, "rem");
        do_op(0, 3'b101, 32'd100, 32'd7, "divu");
        do_op(0, 3'b111, 32'd100, 32'd7, "remu");
        for (int i = 4; i < 8; i++) do_op(0, 3'(i), 32'h1234, 32'd0, "div0");
        do_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_div");
        do_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_rem");

        // Flush mid-divide: no done, result retained
        @(negedge clk);
        funct3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0; k = 1;
        while (k < 10) begin @(negedge clk); k++; end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_out", {30'b0, busy, done}, 32'd0);
        chk("flush_res", result, last_exp);
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= done; end
        chk("flush_nodone", 32'(seen), 32'd0);

        // Starts while busy and during DONE are ignored; next MUL starts at T+34
        @(negedge clk);
        funct3 = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk); start = 1'b0; k = 1;
        while (k < 5) begin @(negedge clk); k++; end
        funct3 = 3'b101; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk); start = 1'b0; k++;
        while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("ign_lat", k, 33);
        chk("ign_res", result, 32'hFFFF_FFEB);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ign_done_start", {30'b0, busy, done}, 32'd0);
        do_op(1, 3'b000, 32'd12345, 32'hFFFF_0001, "mul_t34");

        // Reset mid-operation
        @(negedge clk);
        funct3 = 3'b001; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
        @(negedge clk); start = 1'b0; k = 1;
        while (k < 20) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_out", {30'b0, busy, done}, 32'd0);
        chk("rst_mid_res", result, 32'd0);
        @(negedge clk);
        chk("rst_mid_nodone", 32'(done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = -32'($urandom_range(0, 1000));
                default: ;
            endcase
            do_op(0, rf, ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit, fed directly by the register file's two read ports (`reg_a`/`reg_b` → `a`/`b`). It accepts one operation per start pulse, runs a 32-step shift-add or restoring-divide sequence, then holds a single-cycle `done` with the 32-bit result for the writeback path. The pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `funct3`  in  3  RV32M op:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand.
- `b`  in  32  rs2 operand.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  result; holds the last value until the next `done`.

## Operation
- States:
  - IDLE: `start` captures `funct3`, `|a|`, `|b|` and the sign flags.
    - Divide with `b==0`, or DIV/REM with `a==0x80000000, b==0xFFFFFFFF`: go straight to DONE.
    - All other ops: go to CALC with step counter = 0.
  - CALC: one iteration per cycle; counter increments; at counter==31 go to DONE.
  - DONE: `done=1`, `result` valid; go to IDLE next edge.
- Sign handling:
  - MUL/MULH/DIV/REM: both operands treated as signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - The core works on magnitudes (unsigned); the final negation is applied when entering DONE.
- Multiply: 64-bit shift-add accumulator.
  - Product is negated iff the operand signs differ (considering only the signed operands).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: restoring, 32 iterations, 33-bit partial remainder.
  - Quotient is negated iff the signs differ.
  - Remainder takes the sign of `a`.
- Special results (no iteration):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `a`.
  - Overflow: DIV → 0x80000000; REM → 0.
- `start` while `busy`: ignored, with no effect on the in-flight op.
- `start` in the same cycle as DONE: ignored; it must be re-presented once in IDLE.
- `flush`: has priority over `start` and the state transitions.
  - Any state → IDLE next edge; `done` is not raised.
  - `result` keeps its previous value.
- Operands are registered at accept; `a`/`b`/`funct3` may change afterward without effect.

## Timing
- Reset: state=IDLE, `busy=0`, `done=0`, `result=0`, counter=0, internal accumulators=0.
- Reset asserted mid-operation: same as flush; all outputs take their reset values after the edge.
- Normal op with `start` high in cycle T:
  - `busy` is high in cycles T+1..T+33.
  - `done` is high in cycle T+33 only.
  - Total latency is 33 cycles.
- Special case with `start` in cycle T: `busy` and `done` high in cycle T+1 only.
- Back-to-back: the earliest next accept is the cycle after `done` (T+34), giving 34-cycle throughput.
- `done` is never high for two consecutive cycles.
- `done` is never high in the cycle after `flush` or `rst`.

## Test plan
- MUL `a=7`, `b=-3` (0xFFFFFFFD): `done` at T+33, `result=0xFFFFFFEB`. MULH on the same operands: `result=0xFFFFFFFF`.
- MULHU `a=b=0xFFFFFFFF`: `result=0xFFFFFFFE`. MULHSU `a=-1`, `b=2`: `result=0xFFFFFFFF`.
- DIV `a=-7`, `b=2`: `result=0xFFFFFFFD`. REM: `result=0xFFFFFFFF`. DIVU `a=100`, `b=7`: `result=14`. REMU: `result=2`.
- Divide `b=0`, `a=0x1234`: `done` at T+1.
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → 0x1234.
- DIV `0x80000000 / 0xFFFFFFFF`: `done` at T+1, `result=0x80000000`. REM: `result=0`.
- Control stimulus:
  - Start DIVU, pulse `flush` at T+10: `busy=0` from T+11, no `done`, `result` unchanged.
  - `start` pulses at T+5 and during DONE: ignored.
  - Start MUL at T+34: completes at T+67.
  - `rst` at T+20 mid-op: all outputs zero.
